// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 keypad scanner: FSM state encoding, column strobes,
// note-map offset.
package keypad_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StScan     = 2'd0;
    localparam state_t StDebounce = 2'd1;
    localparam state_t StPressed  = 2'd2;
    localparam state_t StRelease  = 2'd3;

    // Active-low column strobes in rotation order.
    localparam logic [3:0] ColStrobe0 = 4'b1110;
    localparam logic [3:0] ColStrobe1 = 4'b1101;
    localparam logic [3:0] ColStrobe2 = 4'b1011;
    localparam logic [3:0] ColStrobe3 = 4'b0111;

    localparam logic [3:0] RowsIdle   = 4'b1111;
    localparam logic [3:0] NoteOffset = 4'd1;

    function automatic logic [3:0] col_strobe(input logic [1:0] idx);
        logic [3:0] s;
        case (idx)
            2'd0:    s = ColStrobe0;
            2'd1:    s = ColStrobe1;
            2'd2:    s = ColStrobe2;
            default: s = ColStrobe3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan-tick divider: one-clk strobe every SCAN_DIV clks, first one SCAN_DIV clks after reset.
module keypad_tick_gen
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] Wrap = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic            tick_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (cnt_q == Wrap);
            cnt_q  <= (cnt_q == Wrap) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and release tracking.
// Optional macro KEYPAD_NOTE_MAP_EN restricts keys to indices 0..7 and reports index+1.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DEBOUNCE_N = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_press,
    output logic       key_held
);

    localparam logic [3:0] Last = 4'(DEBOUNCE_N - 1);

    logic       tick;
    logic [3:0] row_meta_q, row_sync_q;
    state_t     state_q, state_d;
    logic [1:0] col_q, col_d, row_q, row_d;
    logic [3:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0] code_q, code_d, new_code;
    logic       press_q, press_d, held_q, held_d;
    logic [3:0] row_act;
    logic       row_hit, latched_low;
    logic [1:0] row_sel;

    keypad_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_meta_q <= RowsIdle;
            row_sync_q <= RowsIdle;
        end else begin
            row_meta_q <= row_n;
            row_sync_q <= row_meta_q;
        end
    end

    always_comb begin
        row_act = ~row_sync_q;
`ifdef KEYPAD_NOTE_MAP_EN
        // Rows 2 and 3 map to indices 8..15, which have no note.
        row_act[3:2] = 2'b00;
`endif
        row_hit = |row_act;
        row_sel = 2'd0;
        if (row_act[0])      row_sel = 2'd0;
        else if (row_act[1]) row_sel = 2'd1;
        else if (row_act[2]) row_sel = 2'd2;
        else if (row_act[3]) row_sel = 2'd3;
    end

    assign latched_low = ~row_sync_q[row_q];
    assign cnt_inc     = cnt_q + 4'd1;

`ifdef KEYPAD_NOTE_MAP_EN
    assign new_code = {row_q, col_q} + NoteOffset;
`else
    assign new_code = {row_q, col_q};
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        press_d = 1'b0;
        held_d  = held_q;
        if (tick) begin
            case (state_q)
                StScan: begin
                    if (!row_hit) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        row_d   = row_sel;
                        cnt_d   = '0;
                        state_d = StDebounce;
                    end
                end
                StDebounce: begin
                    if (latched_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == Last) begin
                            state_d = StPressed;
                            press_d = 1'b1;
                            held_d  = 1'b1;
                            code_d  = new_code;
                        end
                    end else begin
                        state_d = StScan;
                    end
                end
                StPressed: begin
                    if (!latched_low) begin
                        cnt_d   = '0;
                        state_d = StRelease;
                    end
                end
                StRelease: begin
                    if (latched_low) begin
                        state_d = StPressed;
                    end else if (row_sync_q == RowsIdle) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == Last) begin
                            held_d  = 1'b0;
                            col_d   = col_q + 2'd1;
                            state_d = StScan;
                        end
                    end
                end
                default: state_d = StScan;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StScan;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            cnt_q   <= '0;
            code_q  <= '0;
            press_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            press_q <= press_d;
            held_q  <= held_d;
        end
    end

    assign col_n     = col_strobe(col_q);
    assign key_code  = code_q;
    assign key_press = press_q;
    assign key_held  = held_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per scan tick (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Parameter DEBOUNCE_N, default 8: consecutive identical scan-tick samples needed to accept a press or release; legal range 2..15.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 col_n  output  4  column strobes, active-low, exactly one low at any time after reset.
REQ-007 key_code  output  4  code of the accepted key; held until the next accepted press.
REQ-008 key_press  output  1  one-clk pulse per accepted press; drives the game's keypad_enable and keypad_input pair.
REQ-009 key_held  output  1  high from the key_press cycle until the release is accepted.

Function
REQ-010 row_n SHALL pass a 2-flop synchroniser; all decisions use the synchronised value.
REQ-011 A scan tick SHALL be a one-clk strobe every SCAN_DIV clks; the divider wraps from SCAN_DIV-1 to 0.
REQ-012 The FSM SHALL have states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-013 SCAN: on each tick, sample rows for the active column. If all rows are high, rotate col_n 1110->1101->1011->0111->1110. Otherwise latch col and lowest active row, clear the counter, and go to DEBOUNCE.
REQ-014 DEBOUNCE: the column is frozen. On each tick, if the latched row is still low, increment the counter. If it reaches DEBOUNCE_N-1, go to PRESSED and assert key_press for exactly one clk. If the row is high, return to SCAN with no output.
REQ-015 On the PRESSED entry cycle, key_code SHALL load index = row*4+col (4-bit, no overflow) and key_held SHALL rise.
REQ-016 PRESSED: on each tick with the latched row high, go to RELEASE with the counter cleared. Other rows going low are ignored (no second press while one is held).
REQ-017 RELEASE: on each tick, if all rows are high, increment the counter. On reaching DEBOUNCE_N-1, drop key_held, resume SCAN at the next column. If the latched row is low, return to PRESSED with no new key_press.
REQ-018 Simultaneous keys in one column: lowest row index wins. Keys in different columns: first column scanned wins.
REQ-019 Latency from a clean stable press to key_press SHALL be at most (4+DEBOUNCE_N)*SCAN_DIV+3 clks.
REQ-020 key_press SHALL never be high in two consecutive clks.

Reset
REQ-021 While reset_n is low: col_n=1110, key_code=0, key_press=0, key_held=0, state=SCAN, all counters and sync flops 0 (sync flops 1 for row_n).
REQ-022 Reset asserted mid-debounce or mid-press SHALL abort with no key_press.
REQ-023 After reset_n deasserts, the first tick occurs SCAN_DIV clks later.

Configuration
REQ-024 Macro KEYPAD_NOTE_MAP_EN.
- Defined: only indices 0..7 are accepted and key_code=index+1 (note codes 1..8, matching the game's note encoding). Indices 8..15 are treated as no key in SCAN.
- Undefined: all 16 keys are accepted and key_code=index.

Structure
REQ-025 Shared package keypad_pkg SHALL hold the FSM state enum, the column rotation constants, and the note-map offset constant.
REQ-026 Sub-module keypad_tick_gen SHALL implement the SCAN_DIV divider and tick strobe; everything else stays in keypad_scanner.

Verification
REQ-027 SCAN_DIV=4, DEBOUNCE_N=3. Key row1/col2 held low 20 ticks -> one key_press, key_code=6 (7 with KEYPAD_NOTE_MAP_EN), key_held high until 3 ticks after release.
REQ-028 Bounce: row0/col0 low 1 tick, high 1 tick, repeated 5 times, then stable -> no key_press during bounce, exactly one after the stable period, key_code=0 (1 with map).
REQ-029 row0 and row3 low in col1 together -> key_code=1. Pressing col3 row2 while held -> no second key_press.
REQ-030 reset_n pulsed low during DEBOUNCE -> no key_press; outputs at reset values; col_n=1110.
REQ-031 With KEYPAD_NOTE_MAP_EN, key index 12 held -> no key_press and col_n keeps rotating. Without the macro -> key_press with key_code=12.
